// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, decode selectors and sequencer states,
// used by both the ALU sequencer and the main control unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_OR      = 4'b0001,
    OP_NOR     = 4'b0010,
    OP_ADD     = 4'b0011,
    OP_SUB     = 4'b0100,
    OP_SLL     = 4'b0101,
    OP_SRL     = 4'b0110,
    OP_MULT    = 4'b0111,
    OP_ILLEGAL = 4'b1001
  } alu_code_e;

  // Operation classes on alu_op; only the R-type class looks at the funct field.
  localparam logic [2:0] CLS_RTYPE = 3'b111;
  localparam logic [2:0] CLS_ADDI  = 3'b100;
  localparam logic [2:0] CLS_ORI   = 3'b101;
  localparam logic [2:0] CLS_BEQ   = 3'b110;
  localparam logic [2:0] CLS_ANDI  = 3'b011;

  localparam logic [8:0] SEL_AND  = {CLS_RTYPE, 6'b100100};
  localparam logic [8:0] SEL_OR   = {CLS_RTYPE, 6'b100101};
  localparam logic [8:0] SEL_NOR  = {CLS_RTYPE, 6'b100111};
  localparam logic [8:0] SEL_ADD  = {CLS_RTYPE, 6'b100000};
  localparam logic [8:0] SEL_SUB  = {CLS_RTYPE, 6'b100010};
  localparam logic [8:0] SEL_SLL  = {CLS_RTYPE, 6'b000000};
  localparam logic [8:0] SEL_SRL  = {CLS_RTYPE, 6'b000010};
  localparam logic [8:0] SEL_MULT = {CLS_RTYPE, 6'b011000};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_shift(alu_code_e code);
    return (code == OP_SLL) || (code == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of {alu_op, alu_function} into a 4-bit ALU operation code.
module alu_decode
  import alu_pkg::*;
#(
  parameter int MULT_EN = 1
)
(
  input  logic [2:0] alu_op,
  input  logic [5:0] alu_function,
  output logic [3:0] operation,
  output logic       illegal
);

  alu_code_e code;

  always_comb begin
    code = OP_ILLEGAL;
    case (alu_op)
      CLS_RTYPE: begin
        case ({alu_op, alu_function})
          SEL_AND:  code = OP_AND;
          SEL_OR:   code = OP_OR;
          SEL_NOR:  code = OP_NOR;
          SEL_ADD:  code = OP_ADD;
          SEL_SUB:  code = OP_SUB;
          SEL_SLL:  code = OP_SLL;
          SEL_SRL:  code = OP_SRL;
          SEL_MULT: begin
            // Builds without the multiplier treat MULT like any unknown funct.
            if (MULT_EN != 0) code = OP_MULT;
            else              code = OP_ILLEGAL;
          end
          default:  code = OP_ILLEGAL;
        endcase
      end
      CLS_ADDI: code = OP_ADD;
      CLS_ORI:  code = OP_OR;
      CLS_BEQ:  code = OP_SUB;
      CLS_ANDI: code = OP_AND;
      default:  code = OP_ILLEGAL;
    endcase
  end

  assign operation = code;
  assign illegal   = (code == OP_ILLEGAL);

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts and a
// shift-add multiplier, all reporting through one registered result port.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHW     = $clog2(WIDTH),
  parameter int MULT_EN = 1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       alu_function,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_operation,
  output logic             illegal,
  output logic             busy,
  output logic             done
);

  logic [3:0] dec_operation;
  logic       dec_illegal;
  alu_code_e  dec_code;

  alu_decode #(.MULT_EN(MULT_EN)) u_decode (
    .alu_op       (alu_op),
    .alu_function (alu_function),
    .operation    (dec_operation),
    .illegal      (dec_illegal)
  );

  assign dec_code = alu_code_e'(dec_operation);

  state_e           state_reg,   state_next;
  alu_code_e        code_reg,    code_next;
  logic             illegal_reg, illegal_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic             zero_reg,    zero_next;
  logic [WIDTH-1:0] a_reg,       a_next;
  logic [WIDTH-1:0] b_reg,       b_next;
  logic [WIDTH-1:0] acc_reg,     acc_next;
  logic [SHW-1:0]   cnt_reg,     cnt_next;

  logic [WIDTH-1:0] single_value;
  logic [WIDTH-1:0] shift_value;
  logic [WIDTH-1:0] mul_sum;

  // Shifts only reach this path with shamt == 0, so they simply pass b through.
  always_comb begin
    single_value = '0;
    case (dec_code)
      OP_AND:  single_value = a & b;
      OP_OR:   single_value = a | b;
      OP_NOR:  single_value = ~(a | b);
      OP_ADD:  single_value = a + b;
      OP_SUB:  single_value = a - b;
      OP_SLL:  single_value = b;
      OP_SRL:  single_value = b;
      default: single_value = '0;
    endcase
  end

  assign shift_value = (code_reg == OP_SLL) ? (b_reg << 1) : (b_reg >> 1);
  assign mul_sum     = acc_reg + (b_reg[0] ? a_reg : '0);

  always_comb begin
    state_next   = state_reg;
    code_next    = code_reg;
    illegal_next = illegal_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          code_next    = dec_code;
          illegal_next = dec_illegal;
          a_next       = a;
          b_next       = b;
          acc_next     = '0;
          if (is_shift(dec_code) && (shamt != '0)) begin
            cnt_next   = shamt - SHW'(1);
            state_next = ST_SHIFT;
          end else if (dec_code == OP_MULT) begin
            cnt_next   = SHW'(WIDTH - 1);
            state_next = ST_MUL;
          end else begin
            result_next = single_value;
            zero_next   = (single_value == '0);
            state_next  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        b_next   = shift_value;
        cnt_next = cnt_reg - SHW'(1);
        if (cnt_reg == '0) begin
          result_next = shift_value;
          zero_next   = (shift_value == '0);
          state_next  = ST_DONE;
        end
      end
      ST_MUL: begin
        // Multiplicand walks left while the multiplier is consumed LSB first.
        acc_next = mul_sum;
        a_next   = a_reg << 1;
        b_next   = b_reg >> 1;
        cnt_next = cnt_reg - SHW'(1);
        if (cnt_reg == '0) begin
          result_next = mul_sum;
          zero_next   = (mul_sum == '0);
          state_next  = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      code_reg    <= OP_AND;
      illegal_reg <= 1'b0;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      code_reg    <= code_next;
      illegal_reg <= illegal_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign result        = result_reg;
  assign zero          = zero_reg;
  assign alu_operation = code_reg;
  assign illegal       = illegal_reg;
  assign busy          = (state_reg == ST_SHIFT) || (state_reg == ST_MUL);
  assign done          = (state_reg == ST_DONE);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: a 32-bit build with the multiplier and an
// 8-bit build without it, both checked against an arithmetic reference model.
module tb_alu_seq_unit;

  typedef struct {
    logic [63:0] result;
    logic        zero;
    logic [3:0]  code;
    logic        illegal;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        start32 = 1'b0;
  logic [2:0]  op32 = '0;
  logic [5:0]  fn32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [4:0]  sh32 = '0;
  logic [31:0] res32;
  logic        zero32, ill32, busy32, done32;
  logic [3:0]  code32;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [5:0]  fn8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  sh8 = '0;
  logic [7:0]  res8;
  logic        zero8, ill8, busy8, done8;
  logic [3:0]  code8;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   busy_n32 = 0, busy_n8 = 0;
  logic [8:0] enc_tab [12];

  alu_seq_unit #(.WIDTH(32), .MULT_EN(1)) dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .alu_op(op32), .alu_function(fn32),
    .a(a32), .b(b32), .shamt(sh32), .result(res32), .zero(zero32),
    .alu_operation(code32), .illegal(ill32), .busy(busy32), .done(done32)
  );

  alu_seq_unit #(.WIDTH(8), .MULT_EN(0)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .alu_op(op8), .alu_function(fn8),
    .a(a8), .b(b8), .shamt(sh8), .result(res8), .zero(zero8),
    .alu_operation(code8), .illegal(ill8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decode table plus plain arithmetic on masked operands.
  function automatic exp_t model(int w, bit men, logic [2:0] op, logic [5:0] fn,
                                 logic [63:0] av, logic [63:0] bv, int sh);
    exp_t e;
    logic [63:0] mask;
    logic [3:0]  c;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    av = av & mask;
    bv = bv & mask;
    c = 4'd9;
    if (op == 3'b111) begin
      case (fn)
        6'b100100: c = 4'd0;
        6'b100101: c = 4'd1;
        6'b100111: c = 4'd2;
        6'b100000: c = 4'd3;
        6'b100010: c = 4'd4;
        6'b000000: c = 4'd5;
        6'b000010: c = 4'd6;
        6'b011000: c = men ? 4'd7 : 4'd9;
        default:   c = 4'd9;
      endcase
    end else if (op == 3'b100) c = 4'd3;
    else if (op == 3'b101) c = 4'd1;
    else if (op == 3'b110) c = 4'd4;
    else if (op == 3'b011) c = 4'd0;
    case (c)
      4'd0:    e.result = av & bv;
      4'd1:    e.result = av | bv;
      4'd2:    e.result = ~(av | bv);
      4'd3:    e.result = av + bv;
      4'd4:    e.result = av - bv;
      4'd5:    e.result = bv << sh;
      4'd6:    e.result = bv >> sh;
      4'd7:    e.result = av * bv;
      default: e.result = 64'd0;
    endcase
    e.result  = e.result & mask;
    e.zero    = (e.result == 64'd0);
    e.code    = c;
    e.illegal = (c == 4'd9);
    e.lat     = 1;
    if ((c == 4'd5 || c == 4'd6) && sh != 0) e.lat = sh + 1;
    else if (c == 4'd7) e.lat = w + 1;
    e.t0 = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) busy_n32 = 0;
    else begin
      if (busy32) busy_n32++;
      if (done32) begin
        chk("busy_with_done32", {63'd0, busy32}, 64'd0);
        if (q32.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done32: got done, want no pending op (cycle %0d)", cyc);
        end else begin
          e32 = q32.pop_front();
          chk("result32",  64'(res32), e32.result);
          chk("zero32",    64'(zero32), 64'(e32.zero));
          chk("code32",    64'(code32), 64'(e32.code));
          chk("illegal32", 64'(ill32), 64'(e32.illegal));
          chk("latency32", 64'(cyc - e32.t0), 64'(e32.lat));
          chk("busycyc32", 64'(busy_n32), 64'(e32.lat - 1));
        end
        busy_n32 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) busy_n8 = 0;
    else begin
      if (busy8) busy_n8++;
      if (done8) begin
        chk("busy_with_done8", {63'd0, busy8}, 64'd0);
        if (q8.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done8: got done, want no pending op (cycle %0d)", cyc);
        end else begin
          e8 = q8.pop_front();
          chk("result8",  64'(res8), e8.result);
          chk("zero8",    64'(zero8), 64'(e8.zero));
          chk("code8",    64'(code8), 64'(e8.code));
          chk("illegal8", 64'(ill8), 64'(e8.illegal));
          chk("latency8", 64'(cyc - e8.t0), 64'(e8.lat));
          chk("busycyc8", 64'(busy_n8), 64'(e8.lat - 1));
        end
        busy_n8 = 0;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the first
  // idle cycle after done. junk=1 hammers start and operands while in flight.
  task automatic issue32(logic [2:0] op, logic [5:0] fn, logic [31:0] av,
                         logic [31:0] bv, logic [4:0] sh, bit junk);
    exp_t e;
    int n;
    op32 = op; fn32 = fn; a32 = av; b32 = bv; sh32 = sh; start32 = 1'b1;
    e = model(32, 1'b1, op, fn, 64'(av), 64'(bv), int'(sh));
    e.t0 = cyc;
    q32.push_back(e);
    $display("w32 op=%b fn=%b a=%h b=%h sh=%0d -> exp %h code=%b lat=%0d",
             op, fn, av, bv, sh, e.result[31:0], e.code, e.lat);
    @(negedge clk);
    start32 = 1'b0;
    n = 0;
    while (!done32 && n < 80) begin
      if (junk) begin
        start32 = 1'($urandom); op32 = 3'($urandom); fn32 = 6'($urandom);
        a32 = $urandom; b32 = $urandom; sh32 = 5'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (!done32) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout32: got no done in 80 cycles, want done (cycle %0d)", cyc);
    end
    start32 = junk;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(logic [2:0] op, logic [5:0] fn, logic [7:0] av,
                        logic [7:0] bv, logic [2:0] sh, bit junk);
    exp_t e;
    int n;
    op8 = op; fn8 = fn; a8 = av; b8 = bv; sh8 = sh; start8 = 1'b1;
    e = model(8, 1'b0, op, fn, 64'(av), 64'(bv), int'(sh));
    e.t0 = cyc;
    q8.push_back(e);
    $display("w8  op=%b fn=%b a=%h b=%h sh=%0d -> exp %h code=%b lat=%0d",
             op, fn, av, bv, sh, e.result[7:0], e.code, e.lat);
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      if (junk) begin
        start8 = 1'($urandom); op8 = 3'($urandom); fn8 = 6'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); sh8 = 3'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (!done8) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout8: got no done in 40 cycles, want done (cycle %0d)", cyc);
    end
    start8 = junk;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  initial begin
    logic [8:0] enc;
    logic [5:0] fn;
    int k;
    enc_tab = '{9'b111_100100, 9'b111_100101, 9'b111_100111, 9'b111_100000,
                9'b111_100010, 9'b111_000000, 9'b111_000010, 9'b111_011000,
                9'b100_000000, 9'b101_000000, 9'b110_000000, 9'b011_000000};

    repeat (3) @(negedge clk);
    chk("rst_result32", 64'(res32), 64'd0);
    chk("rst_zero32",   64'(zero32), 64'd0);
    chk("rst_code32",   64'(code32), 64'd0);
    chk("rst_ill32",    64'(ill32), 64'd0);
    chk("rst_busy32",   64'(busy32), 64'd0);
    chk("rst_done32",   64'(done32), 64'd0);
    chk("rst_result8",  64'(res8), 64'd0);
    rst_n = 1'b1;

    // Directed cases from the requirements, first one on the release edge.
    issue32(3'b111, 6'b100000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    issue32(3'b111, 6'b000000, 32'h0000_0000, 32'h0000_0001, 5'd31, 1'b0);
    issue32(3'b111, 6'b011000, 32'h0001_0000, 32'h0001_0003, 5'd0, 1'b1);
    issue32(3'b111, 6'b001000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0);
    issue32(3'b111, 6'b000010, 32'h0000_0000, 32'h8000_0000, 5'd0, 1'b1);
    issue32(3'b111, 6'b100000, 32'h0000_1234, 32'h0000_0001, 5'd0, 1'b0);

    // MULT interrupted by reset in its tenth cycle; nothing is expected from it.
    op32 = 3'b111; fn32 = 6'b011000; a32 = 32'h0000_0003; b32 = 32'h0000_0005;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result32", 64'(res32), 64'd0);
    chk("arst_zero32",   64'(zero32), 64'd0);
    chk("arst_code32",   64'(code32), 64'd0);
    chk("arst_ill32",    64'(ill32), 64'd0);
    chk("arst_busy32",   64'(busy32), 64'd0);
    chk("arst_done32",   64'(done32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue32(3'b111, 6'b100010, 32'd5, 32'd7, 5'd0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 12);
      enc = (k == 12) ? 9'($urandom) : enc_tab[k];
      fn = enc[5:0];
      if (enc[8:6] != 3'b111) fn = 6'($urandom);
      issue32(enc[8:6], fn, $urandom,
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
              5'($urandom), 1'($urandom));
    end

    issue8(3'b111, 6'b011000, 8'h12, 8'h34, 3'd0, 1'b0);
    issue8(3'b111, 6'b000010, 8'h00, 8'h80, 3'd7, 1'b1);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 12);
      enc = (k == 12) ? 9'($urandom) : enc_tab[k];
      fn = enc[5:0];
      if (enc[8:6] != 3'b111) fn = 6'($urandom);
      issue8(enc[8:6], fn, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("pending32", 64'(q32.size()), 64'd0);
    chk("pending8",  64'(q8.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running at 5 ms, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
